two_bit_divider: RTL and testbench

TWO_BIT_DIVIDER -- requirements
Module: two_bit_divider

---
 rtl/two_bit_divider_if.sv | 22 ++
 rtl/two_bit_divider.sv | 133 +++++++++++++
 tb/tb_two_bit_divider.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/two_bit_divider_if.sv
// Handshake and data bundle for two_bit_divider: the requester drives the
// master side, the divider sits on the slave side.
interface two_bit_divider_if;
    logic       start;
    logic [3:0] dividend;
    logic [1:0] divisor;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, err
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, err
    );
endinterface

// File: rtl/two_bit_divider.sv
// 4-bit by 2-bit restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_ZERO_DETECT_EN to short-circuit divisor=0 and raise err.
module two_bit_divider (
    input logic              clk,
    input logic              rst,
    two_bit_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] dvd_q, dvd_d;
    logic [1:0] dvs_q, dvs_d;
    logic [1:0] rem_q, rem_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] quotient_q, quotient_d;
    logic [1:0] remainder_q, remainder_d;
    logic       done_q, done_d;
    logic [2:0] partial;
    logic       qbit;
`ifdef DIV_ZERO_DETECT_EN
    logic       zero_q, zero_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        zero_d      = zero_q;
        err_d       = err_q;
`endif
        partial     = {rem_q, dvd_q[3]};
        qbit        = (partial >= {1'b0, dvs_q});

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    zero_d  = 1'b0;
                    if (bus.divisor == 2'd0) begin
                        quo_d   = '1;
                        rem_d   = bus.dividend[1:0];
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // rem < divisor keeps partial - divisor inside 2 bits; with
                // divisor=0 the truncation yields dividend[1:0] after 4 steps.
                rem_d = qbit ? 2'(partial - {1'b0, dvs_q}) : partial[1:0];
                quo_d = {quo_q[2:0], qbit};
                dvd_d = {dvd_q[2:0], 1'b0};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Results publish as busy falls, so they never move while busy.
                quotient_d  = quo_q;
                remainder_d = rem_q;
                done_d      = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                err_d       = zero_q;
`endif
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            zero_q      <= zero_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_two_bit_divider.sv
// Bench for two_bit_divider: transaction-level reference model with a per-cycle
// compare, directed cases with literal expectations, and random traffic.
module tb_two_bit_divider;
    logic clk = 1'b0;
    logic rst;

    two_bit_divider_if bus_if ();

    two_bit_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted request completes a fixed number of edges later.
    int m_left = 0;
    int m_q = 0, m_r = 0, m_err = 0, m_done = 0;
    int p_q = 0, p_r = 0, p_err = 0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_left <= 0;
            m_q    <= 0;
            m_r    <= 0;
            m_err  <= 0;
            m_done <= 0;
        end else begin
            m_done <= 0;
            if (m_left == 0) begin
                if (bus_if.start === 1'b1) begin
                    if (int'(bus_if.divisor) == 0) begin
                        p_q    <= 15;
                        p_r    <= int'(bus_if.dividend) % 4;
                        p_err  <= ZD ? 1 : 0;
                        m_left <= ZD ? 1 : 5;
                    end else begin
                        p_q    <= int'(bus_if.dividend) / int'(bus_if.divisor);
                        p_r    <= int'(bus_if.dividend) % int'(bus_if.divisor);
                        p_err  <= 0;
                        m_left <= 5;
                    end
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_err  <= p_err;
                    m_done <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_busy",      32'(bus_if.busy),      32'(m_left != 0));
            chk("model_done",      32'(bus_if.done),      32'(m_done));
            chk("model_quotient",  32'(bus_if.quotient),  32'(m_q));
            chk("model_remainder", 32'(bus_if.remainder), 32'(m_r));
            chk("model_err",       32'(bus_if.err),       32'(m_err));
        end
    end

    // Issue one request from idle and wait (bounded) for its done pulse.
    task automatic run_op(input int a, input int b, output int q, output int r,
                          output int e, output int lat);
        int found;
        found = 0;
        lat = -1;
        q = 0; r = 0; e = 0;
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.dividend = a[3:0];
        bus_if.divisor  = b[1:0];
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) begin
                lat = n - 1;
                q = int'(bus_if.quotient);
                r = int'(bus_if.remainder);
                e = int'(bus_if.err);
                found = 1;
                break;
            end
        end
        chk("op_done_seen", 32'(found), 32'd1);
    endtask

    initial begin
        int q, r, e, lat, last, pulses, seen, q_prev, r_prev;

        rst = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_quotient",  32'(bus_if.quotient),  32'd0);
        chk("rst_remainder", 32'(bus_if.remainder), 32'd0);
        chk("rst_busy",      32'(bus_if.busy),      32'd0);
        chk("rst_done",      32'(bus_if.done),      32'd0);
        chk("rst_err",       32'(bus_if.err),       32'd0);
        check_en = 1'b1;
        rst = 1'b0;

        run_op(13, 3, q, r, e, lat);
        chk("d13_3_q", 32'(q), 32'd4);
        chk("d13_3_r", 32'(r), 32'd1);
        chk("d13_3_err", 32'(e), 32'd0);
        chk("d13_3_lat", 32'(lat), 32'd5);

        run_op(15, 1, q, r, e, lat);
        chk("d15_1_q", 32'(q), 32'd15);
        chk("d15_1_r", 32'(r), 32'd0);
        run_op(2, 3, q, r, e, lat);
        chk("d2_3_q", 32'(q), 32'd0);
        chk("d2_3_r", 32'(r), 32'd2);
        run_op(0, 2, q, r, e, lat);
        chk("d0_2_q", 32'(q), 32'd0);
        chk("d0_2_r", 32'(r), 32'd0);

        run_op(9, 0, q, r, e, lat);
        chk("d9_0_q", 32'(q), 32'd15);
        chk("d9_0_r", 32'(r), 32'd1);
        chk("d9_0_err", 32'(e), ZD ? 32'd1 : 32'd0);
        chk("d9_0_lat", 32'(lat), ZD ? 32'd1 : 32'd5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 4; b++) begin
                run_op(a, b, q, r, e, lat);
                if (b != 0) begin
                    chk("sweep_identity", 32'(q * b + r), 32'(a));
                    chk("sweep_rem_lt_div", 32'(r < b), 32'd1);
                end else begin
                    chk("sweep_zero_q", 32'(q), 32'd15);
                    chk("sweep_zero_r", 32'(r), 32'(a % 4));
                end
                chk("sweep_err", 32'(e), 32'((b == 0) && ZD));
                chk("sweep_lat", 32'(lat), ((b == 0) && ZD) ? 32'd1 : 32'd5);
            end
        end

        // Second start with new operands during RUN must be ignored.
        q_prev = int'(bus_if.quotient);
        r_prev = int'(bus_if.remainder);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.dividend = 4'd12; bus_if.divisor = 2'd2;
        @(posedge clk);
        @(negedge clk);
        bus_if.dividend = 4'd7; bus_if.divisor = 2'd3;
        seen = 0; q = 0; r = 0;
        for (int n = 0; n < 20; n++) begin
            if (n == 2) bus_if.start = 1'b0;
            if (bus_if.busy === 1'b1) begin
                chk("busy_stable_q", 32'(bus_if.quotient), 32'(q_prev));
                chk("busy_stable_r", 32'(bus_if.remainder), 32'(r_prev));
            end
            if (bus_if.done === 1'b1) begin
                seen++;
                q = int'(bus_if.quotient);
                r = int'(bus_if.remainder);
            end
            @(negedge clk);
        end
        chk("ignore_start_pulses", 32'(seen), 32'd1);
        chk("ignore_start_q", 32'(q), 32'd6);
        chk("ignore_start_r", 32'(r), 32'd0);

        // Reset on the second RUN cycle aborts without a done pulse.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.dividend = 4'd11; bus_if.divisor = 2'd3;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_quotient",  32'(bus_if.quotient),  32'd0);
        chk("abort_remainder", 32'(bus_if.remainder), 32'd0);
        chk("abort_busy",      32'(bus_if.busy),      32'd0);
        chk("abort_done",      32'(bus_if.done),      32'd0);
        chk("abort_err",       32'(bus_if.err),       32'd0);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op(11, 3, q, r, e, lat);
        chk("after_abort_q", 32'(q), 32'd3);
        chk("after_abort_r", 32'(r), 32'd2);

        // Continuous start: results every 6 cycles.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.dividend = 4'd14; bus_if.divisor = 2'd3;
        @(posedge clk);
        last = -1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin
                pulses++;
                chk("b2b_q", 32'(bus_if.quotient), 32'd4);
                chk("b2b_r", 32'(bus_if.remainder), 32'd2);
                if (last >= 0) chk("b2b_interval", 32'(i - last), 32'd6);
                else           chk("b2b_first", 32'(i), 32'd5);
                last = i;
            end
        end
        bus_if.start = 1'b0;
        chk("b2b_count", 32'(pulses), 32'd3);
        repeat (10) @(negedge clk);

        // Random traffic, including occasional resets, against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst             = ($urandom_range(0, 49) == 0);
            bus_if.start    = ($urandom_range(0, 3) != 0);
            bus_if.dividend = 4'($urandom_range(0, 15));
            bus_if.divisor  = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b0;
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
